// File: rtl/eth_bd_ram_arb_if.sv
// Signal bundle between the descriptor-RAM arbiter, its two requesters and the RAM.
// Latency: none; it only groups wires.
// Backpressure: requesters hold req until ack, and the arbiter paces the RAM.
//
// Port summary
//   host_* : register-bus slave access (req/we/sel/addr/wdata in, ack/rdata out)
//   mac_*  : descriptor DMA access, same shape as host_*
//   ram_*  : initiator side of eth_spram_256x32 (ce/we/oe/addr/di out, do in)
// Modports
//   slave  : the arbiter's view. It serves both requesters and drives the RAM.
//   master : the environment's view. It holds the requesters and the RAM model.
interface eth_bd_ram_arb_if;
    logic        host_req;
    logic        host_we;
    logic [3:0]  host_sel;
    logic [7:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_ack;
    logic [31:0] host_rdata;

    logic        mac_req;
    logic        mac_we;
    logic [3:0]  mac_sel;
    logic [7:0]  mac_addr;
    logic [31:0] mac_wdata;
    logic        mac_ack;
    logic [31:0] mac_rdata;

    logic        ram_ce;
    logic [3:0]  ram_we;
    logic        ram_oe;
    logic [7:0]  ram_addr;
    logic [31:0] ram_di;
    logic [31:0] ram_do;

    modport slave (
        input  host_req, host_we, host_sel, host_addr, host_wdata,
        output host_ack, host_rdata,
        input  mac_req, mac_we, mac_sel, mac_addr, mac_wdata,
        output mac_ack, mac_rdata,
        output ram_ce, ram_we, ram_oe, ram_addr, ram_di,
        input  ram_do
    );

    modport master (
        output host_req, host_we, host_sel, host_addr, host_wdata,
        input  host_ack, host_rdata,
        output mac_req, mac_we, mac_sel, mac_addr, mac_wdata,
        input  mac_ack, mac_rdata,
        input  ram_ce, ram_we, ram_oe, ram_addr, ram_di,
        output ram_do
    );
endinterface

// File: rtl/eth_bd_ram_arb.sv
// Host / MAC-DMA arbiter and access sequencer for the 256x32 buffer-descriptor RAM.
// Latency: a write is acked 2 cycles after the IDLE sample, and a read 3 cycles after it.
// Backpressure: req is held until a 1-cycle ack. The loser waits at most one access.
//
// Ports
//   clk  : rising-edge clock
//   rstn : synchronous reset, active-HIGH (the name is inherited from the RAM)
//   bus  : eth_bd_ram_arb_if.slave, which carries both requester buses and the RAM side
// Parameters
//   MAC_FIRST : 1 means the MAC wins the first contended grant after reset, 0 means the host.
module eth_bd_ram_arb #(
    parameter bit MAC_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    eth_bd_ram_arb_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    // last_mac = 1 when the MAC was the most recently granted requester.
    logic last_mac;
    // The command registers hold the granted access. They load only in IDLE,
    // so the requester inputs may change freely while the access is in progress.
    logic cmd_mac;
    logic cmd_we;

    // Winner selection from the live requests. This path only feeds registers,
    // so nothing on the RAM side depends combinationally on req.
    logic        grant_mac;
    logic        win_we;
    logic [3:0]  win_sel;
    logic [7:0]  win_addr;
    logic [31:0] win_wdata;

    always_comb begin
        grant_mac = bus.mac_req;
        if (bus.mac_req && bus.host_req) begin
            // On contention, grant the requester that was not served last.
            grant_mac = ~last_mac;
        end
        win_we    = grant_mac ? bus.mac_we    : bus.host_we;
        win_sel   = grant_mac ? bus.mac_sel   : bus.host_sel;
        win_addr  = grant_mac ? bus.mac_addr  : bus.host_addr;
        win_wdata = grant_mac ? bus.mac_wdata : bus.host_wdata;
    end

    // Single registered FSM. Each RAM output is set on the edge that enters
    // the state where it must be visible, so all outputs come straight from flops.
    // ram_addr and ram_di double as the latched address and write data, so
    // they stay stable through ISSUE and READ.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state          <= IDLE;
            last_mac       <= ~MAC_FIRST;
            cmd_mac        <= 1'b0;
            cmd_we         <= 1'b0;
            bus.ram_ce     <= 1'b0;
            bus.ram_oe     <= 1'b0;
            bus.ram_we     <= 4'h0;
            bus.ram_addr   <= 8'h00;
            bus.ram_di     <= 32'h0;
            bus.host_ack   <= 1'b0;
            bus.mac_ack    <= 1'b0;
            bus.host_rdata <= 32'h0;
            bus.mac_rdata  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    // The RAM controls are already low on entry to IDLE, either
                    // from DONE or from reset.
                    if (bus.host_req || bus.mac_req) begin
                        cmd_mac      <= grant_mac;
                        cmd_we       <= win_we;
                        last_mac     <= grant_mac;
                        bus.ram_ce   <= 1'b1;
                        // A write with sel = 0 still runs ISSUE but changes no bytes.
                        bus.ram_we   <= win_we ? win_sel : 4'h0;
                        bus.ram_addr <= win_addr;
                        bus.ram_di   <= win_wdata;
                        state        <= ISSUE;
                    end
                end

                ISSUE: begin
                    bus.ram_we <= 4'h0;
                    if (cmd_we) begin
                        bus.ram_ce   <= 1'b0;
                        bus.host_ack <= ~cmd_mac;
                        bus.mac_ack  <= cmd_mac;
                        state        <= DONE;
                    end else begin
                        // The RAM registered the address on this edge. Keep ce
                        // high, hold the same address and open the output enable.
                        bus.ram_oe   <= 1'b1;
                        state        <= READ;
                    end
                end

                READ: begin
                    bus.ram_ce <= 1'b0;
                    bus.ram_oe <= 1'b0;
                    if (cmd_mac) begin
                        bus.mac_rdata  <= bus.ram_do;
                    end else begin
                        bus.host_rdata <= bus.ram_do;
                    end
                    bus.host_ack <= ~cmd_mac;
                    bus.mac_ack  <= cmd_mac;
                    state        <= DONE;
                end

                DONE: begin
                    bus.host_ack <= 1'b0;
                    bus.mac_ack  <= 1'b0;
                    state        <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_bd_ram_arb.sv
// Bench for eth_bd_ram_arb: directed scenarios plus random two-requester traffic,
// checked every cycle against a transaction-level model (grant order, ack cycle,
// RAM strobes, read data) built from the access rules and a plain memory array.
module tb_eth_bd_ram_arb;

    localparam bit MAC_FIRST = 1'b1;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic ram_clr = 1'b1;
    int   cyc = 0;
    logic rst_q;

    always #5 clk = ~clk;

    eth_bd_ram_arb_if bus();

    eth_bd_ram_arb #(.MAC_FIRST(MAC_FIRST)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rstn;
    end

    // ---------------- RAM model: registered address, byte-write ----------------
    logic [31:0] ram_mem [256];
    logic [7:0]  ram_aq;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= 32'h0;
        end else if (bus.ram_ce) begin
            ram_aq <= bus.ram_addr;
            for (int b = 0; b < 4; b++)
                if (bus.ram_we[b]) ram_mem[bus.ram_addr][8*b +: 8] <= bus.ram_di[8*b +: 8];
        end
    end

    assign bus.ram_do = (bus.ram_ce && bus.ram_oe) ? ram_mem[ram_aq] : 32'h0;

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h, required %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // One access is in progress at a time. The arbiter is free to sample the cycle
    // after an ack, or in the first cycle after a reset edge. A write acks 2 cycles
    // after the sample and a read 3 cycles after. RAM strobes follow the sample cycle g:
    // ce in g+1 (and g+2 for reads), oe in g+2 for reads, and we = sel in g+1 for writes.
    logic [31:0] mem_m [256];
    bit          m_busy = 1'b0;
    int          m_free = 0;
    int          m_g = 0;
    bit          m_mac, m_we, m_last_mac;
    logic [3:0]  m_sel;
    logic [7:0]  m_addr;
    logic [31:0] m_wd, m_rdv, m_h_rd, m_m_rd;
    bit          e_h, e_m, e_ce, e_oe, win;
    logic [3:0]  e_we;
    int          ph;

    always @(negedge clk) begin
        if (ram_clr) for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
        if (rst_q) begin
            m_busy     = 1'b0;
            m_free     = cyc;
            m_last_mac = ~MAC_FIRST;
            m_h_rd     = 32'h0;
            m_m_rd     = 32'h0;
        end

        ph   = cyc - m_g;
        e_h  = m_busy && !m_mac && (ph == (m_we ? 2 : 3));
        e_m  = m_busy &&  m_mac && (ph == (m_we ? 2 : 3));
        e_ce = m_busy && (ph == 1 || (!m_we && ph == 2));
        e_oe = m_busy && !m_we && ph == 2;
        e_we = (m_busy && m_we && ph == 1) ? m_sel : 4'h0;
        if (e_h && !m_we) m_h_rd = m_rdv;
        if (e_m && !m_we) m_m_rd = m_rdv;

        check_val("host_ack",   32'(bus.host_ack), 32'(e_h));
        check_val("mac_ack",    32'(bus.mac_ack),  32'(e_m));
        check_val("host_rdata", bus.host_rdata, m_h_rd);
        check_val("mac_rdata",  bus.mac_rdata,  m_m_rd);
        check_val("ram_ce",     32'(bus.ram_ce), 32'(e_ce));
        check_val("ram_oe",     32'(bus.ram_oe), 32'(e_oe));
        check_val("ram_we",     32'(bus.ram_we), 32'(e_we));
        if (e_ce) check_val("ram_addr", 32'(bus.ram_addr), 32'(m_addr));
        if (m_busy && ph == 1) check_val("ram_di", bus.ram_di, m_wd);

        if (e_h || e_m) begin
            m_busy = 1'b0;
            m_free = cyc + 1;
        end

        if (!m_busy && cyc >= m_free && !rstn && (bus.host_req || bus.mac_req)) begin
            win        = (bus.host_req && bus.mac_req) ? ~m_last_mac : bus.mac_req;
            m_mac      = win;
            m_we       = win ? bus.mac_we    : bus.host_we;
            m_sel      = win ? bus.mac_sel   : bus.host_sel;
            m_addr     = win ? bus.mac_addr  : bus.host_addr;
            m_wd       = win ? bus.mac_wdata : bus.host_wdata;
            m_g        = cyc;
            m_busy     = 1'b1;
            m_last_mac = win;
            if (m_we) begin
                for (int b = 0; b < 4; b++)
                    if (m_sel[b]) mem_m[m_addr][8*b +: 8] = m_wd[8*b +: 8];
            end else begin
                m_rdv = mem_m[m_addr];
            end
        end
    end

    // DUT ack order log (1 = MAC, 0 = host)
    bit log_en = 1'b0;
    bit dut_log[$];
    always @(negedge clk) begin
        if (log_en) begin
            if (bus.host_ack) dut_log.push_back(1'b0);
            if (bus.mac_ack)  dut_log.push_back(1'b1);
        end
    end

    // ---------------- requester tasks ----------------
    task automatic host_access(input bit we, input logic [3:0] sel, input logic [7:0] addr,
                               input logic [31:0] wd, output logic [31:0] rd, output int ack_cyc);
        int n;
        @(posedge clk); #1;
        bus.host_we = we; bus.host_sel = sel; bus.host_addr = addr; bus.host_wdata = wd;
        bus.host_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.host_ack && n < 64);
        if (!bus.host_ack) check_val("host_ack_timeout", 32'(bus.host_ack), 32'h1);
        rd = bus.host_rdata;
        ack_cyc = cyc;
        @(posedge clk); #1;
        bus.host_req = 1'b0;
    endtask

    task automatic mac_access(input bit we, input logic [3:0] sel, input logic [7:0] addr,
                              input logic [31:0] wd, output logic [31:0] rd, output int ack_cyc);
        int n;
        @(posedge clk); #1;
        bus.mac_we = we; bus.mac_sel = sel; bus.mac_addr = addr; bus.mac_wdata = wd;
        bus.mac_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.mac_ack && n < 64);
        if (!bus.mac_ack) check_val("mac_ack_timeout", 32'(bus.mac_ack), 32'h1);
        rd = bus.mac_rdata;
        ack_cyc = cyc;
        @(posedge clk); #1;
        bus.mac_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rd, rd2;
    int          c1, c2, n_mac, n_host, n;

    initial begin
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_sel = 4'h0;
        bus.host_addr = 8'h00; bus.host_wdata = 32'h0;
        bus.mac_req = 1'b0; bus.mac_we = 1'b0; bus.mac_sel = 4'h0;
        bus.mac_addr = 8'h00; bus.mac_wdata = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_host_ack",   32'(bus.host_ack), 32'h0);
        check_val("rst_mac_ack",    32'(bus.mac_ack),  32'h0);
        check_val("rst_ram_ce",     32'(bus.ram_ce),   32'h0);
        check_val("rst_ram_oe",     32'(bus.ram_oe),   32'h0);
        check_val("rst_ram_we",     32'(bus.ram_we),   32'h0);
        check_val("rst_ram_addr",   32'(bus.ram_addr), 32'h0);
        check_val("rst_ram_di",     bus.ram_di,        32'h0);
        check_val("rst_host_rdata", bus.host_rdata,    32'h0);
        check_val("rst_mac_rdata",  bus.mac_rdata,     32'h0);
        @(posedge clk); #2;
        ram_clr = 1'b0;
        rstn = 1'b0;

        // Host write then read back
        host_access(1'b1, 4'hF, 8'h10, 32'hDEADBEEF, rd, c1);
        host_access(1'b0, 4'h0, 8'h10, 32'h0, rd, c1);
        check_val("host_readback", rd, 32'hDEADBEEF);

        // Byte enables
        host_access(1'b1, 4'hF, 8'h20, 32'h11223344, rd, c1);
        mac_access(1'b1, 4'b0101, 8'h20, 32'hAABBCCDD, rd, c1);
        mac_access(1'b0, 4'h0, 8'h20, 32'h0, rd, c1);
        check_val("byte_enable_merge", rd, 32'h11BB33DD);

        // Reset during the READ cycle of a host read
        @(posedge clk); #1;
        bus.host_we = 1'b0; bus.host_addr = 8'h10; bus.host_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.ram_oe && n < 16);
        check_val("read_cycle_reached", 32'(bus.ram_oe), 32'h1);
        rstn = 1'b1;
        bus.host_req = 1'b0;
        @(negedge clk);
        check_val("abort_host_ack", 32'(bus.host_ack), 32'h0);
        check_val("abort_ram_ce",   32'(bus.ram_ce),   32'h0);
        check_val("abort_ram_oe",   32'(bus.ram_oe),   32'h0);
        check_val("abort_ram_addr", 32'(bus.ram_addr), 32'h0);
        check_val("abort_rdata",    bus.host_rdata,    32'h0);
        @(posedge clk); #2;
        rstn = 1'b0;
        mac_access(1'b0, 4'h0, 8'h10, 32'h0, rd, c1);
        check_val("post_reset_mac_read", rd, 32'hDEADBEEF);

        // Contention right after reset: MAC first, host 4 cycles later
        do_reset();
        fork
            host_access(1'b0, 4'h0, 8'h10, 32'h0, rd, c1);
            mac_access(1'b0, 4'h0, 8'h20, 32'h0, rd2, c2);
        join
        check_val("contend_host_rd", rd,  32'hDEADBEEF);
        check_val("contend_mac_rd",  rd2, 32'h11BB33DD);
        check_val("contend_gap",     32'(c1 - c2), 32'd4);

        // Fairness: continuous requests from both sides
        do_reset();
        dut_log.delete();
        log_en = 1'b1;
        fork
            begin
                logic [31:0] r; int c;
                for (int i = 0; i < 4; i++) mac_access(1'b0, 4'h0, 8'(i), 32'h0, r, c);
            end
            begin
                logic [31:0] r; int c;
                for (int i = 0; i < 4; i++) host_access(1'b1, 4'hF, 8'(8'h40 + i), $urandom, r, c);
            end
        join
        log_en = 1'b0;
        n_mac = 0; n_host = 0;
        foreach (dut_log[i]) if (dut_log[i]) n_mac++; else n_host++;
        check_val("fair_mac_count",  32'(n_mac),  32'd4);
        check_val("fair_host_count", 32'(n_host), 32'd4);
        if (dut_log.size() > 0) check_val("fair_first_is_mac", 32'(dut_log[0]), 32'h1);
        for (int i = 1; i < dut_log.size(); i++)
            check_val("fair_alternate", 32'(dut_log[i] != dut_log[i-1]), 32'h1);

        // Zero-sel write leaves the word untouched
        host_access(1'b1, 4'hF, 8'h30, 32'h55AA55AA, rd, c1);
        host_access(1'b1, 4'h0, 8'h30, 32'h12345678, rd, c1);
        host_access(1'b0, 4'h0, 8'h30, 32'h0, rd, c1);
        check_val("zero_sel_readback", rd, 32'h55AA55AA);

        // Random traffic from both requesters
        fork
            begin
                logic [31:0] r; int c;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    host_access(1'($urandom), 4'($urandom), 8'($urandom_range(0, 15)), $urandom, r, c);
                end
            end
            begin
                logic [31:0] r; int c;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    mac_access(1'($urandom), 4'($urandom), 8'($urandom_range(0, 15)), $urandom, r, c);
                end
            end
        join

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
